// File: rtl/vpu_sram_responder.sv
// vpu_sram_responder
// Scratchpad-side responder for the vector unit's single-beat SRAM port.
// The VPU issues one-cycle read or write request pulses. Each accepted access
// completes with a one-cycle sram_ready pulse:
//   - writes complete after exactly one cycle;
//   - reads complete after exactly RD_LATENCY cycles, together with the data.
// A DMA write port fills the same array. The array has a single write port,
// and a VPU write takes priority over a DMA write for it.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   sram_addr            VPU word address, valid in the request cycle
//   sram_wdata           VPU write data, valid in the request cycle
//   sram_re / sram_we    one-cycle read / write request pulses
//   sram_rdata           registered read data; changes only when a read completes
//   sram_ready           one-cycle completion pulse
//   dma_we               DMA write request, held until accepted
//   dma_addr, dma_wdata  DMA word address and data
//   dma_ready            DMA write accepted this cycle (combinational)
//   err_range            sticky, set by an out-of-range VPU or DMA address
//   err_proto            sticky, set by an overlapping or simultaneous re+we request
module vpu_sram_responder #(
    parameter int LANES       = 64,
    parameter int DATA_WIDTH  = 16,
    parameter int SRAM_ADDR_W = 20,
    parameter int DEPTH       = 1024,
    parameter int RD_LATENCY  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SRAM_ADDR_W-1:0]      sram_addr,
    input  logic [LANES*DATA_WIDTH-1:0] sram_wdata,
    input  logic                        sram_re,
    input  logic                        sram_we,
    output logic [LANES*DATA_WIDTH-1:0] sram_rdata,
    output logic                        sram_ready,
    input  logic                        dma_we,
    input  logic [SRAM_ADDR_W-1:0]      dma_addr,
    input  logic [LANES*DATA_WIDTH-1:0] dma_wdata,
    output logic                        dma_ready,
    output logic                        err_range,
    output logic                        err_proto
);

    localparam int W     = LANES * DATA_WIDTH;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_RESP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     rd_buf_q, rd_buf_d;
    logic [W-1:0]     rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic             err_range_q, err_range_d;
    logic             err_proto_q, err_proto_d;

    logic [W-1:0]     mem [DEPTH];

    logic             vpu_in_range, dma_in_range;
    logic [IDX_W-1:0] vpu_idx, dma_idx;
    logic             vpu_wr_commit, dma_commit;
    logic [W-1:0]     rd_word;

    // The range checks use one extra bit, so that DEPTH == 2**SRAM_ADDR_W
    // cannot wrap to zero.
    assign vpu_in_range = ({1'b0, sram_addr} < (SRAM_ADDR_W+1)'(DEPTH));
    assign dma_in_range = ({1'b0, dma_addr}  < (SRAM_ADDR_W+1)'(DEPTH));
    assign vpu_idx      = sram_addr[IDX_W-1:0];
    assign dma_idx      = dma_addr[IDX_W-1:0];

    // DMA yields only in the cycle a VPU write is accepted.
    // While reset is held, the state machine is not accepting requests,
    // so DMA is never blocked then.
    assign dma_ready     = rst || !(state_q == IDLE && sram_we);
    assign dma_commit    = dma_we && dma_ready;
    assign vpu_wr_commit = !rst && (state_q == IDLE) && sram_we && vpu_in_range;

    // An out-of-range read samples zero instead of an aliased array word.
    assign rd_word = vpu_in_range ? mem[vpu_idx] : '0;

    // Array write port. The contents are deliberately not reset.
    // A read samples the array in the same cycle that DMA may write the
    // same word, so the read sees the old contents.
    always_ff @(posedge clk) begin
        if (vpu_wr_commit) begin
            mem[vpu_idx] <= sram_wdata;
        end else if (dma_commit && dma_in_range) begin
            mem[dma_idx] <= dma_wdata;
        end
    end

    // Next-state logic.
    // sram_ready is registered, so it is raised at the edge that enters the
    // final cycle of the access: the cycle where the counter reaches zero.
    // With RD_LATENCY == 1 that edge is the accept edge itself.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_buf_d    = rd_buf_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        err_range_d = err_range_q;
        err_proto_d = err_proto_q;

        case (state_q)
            IDLE: begin
                if (sram_we) begin
                    state_d = WR_RESP;
                    ready_d = 1'b1;
                    if (!vpu_in_range) err_range_d = 1'b1;
                    if (sram_re)       err_proto_d = 1'b1;
                end else if (sram_re) begin
                    state_d  = RD_WAIT;
                    cnt_d    = CNT_W'(RD_LATENCY - 1);
                    rd_buf_d = rd_word;
                    if (!vpu_in_range) err_range_d = 1'b1;
                    if (RD_LATENCY == 1) begin
                        ready_d = 1'b1;
                        rdata_d = rd_word;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        ready_d = 1'b1;
                        rdata_d = rd_buf_q;
                    end
                end
            end
            WR_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Requests arriving while an access is in flight are dropped.
        if (state_q != IDLE && (sram_re || sram_we)) err_proto_d = 1'b1;
        if (dma_commit && !dma_in_range)             err_range_d = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_buf_q    <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            err_range_q <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_buf_q    <= rd_buf_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_range_q <= err_range_d;
            err_proto_q <= err_proto_d;
        end
    end

    assign sram_rdata = rdata_q;
    assign sram_ready = ready_q;
    assign err_range  = err_range_q;
    assign err_proto  = err_proto_q;

endmodule

// File: tb/tb_vpu_sram_responder.sv
// tb_vpu_sram_responder
// Directed and randomized bench for vpu_sram_responder.
// The reference model is a sparse word store, updated per transaction in
// program order:
//   - a read observes the store before any DMA write issued in the same cycle;
//   - out-of-range addresses read as zero and never modify the store.
module tb_vpu_sram_responder;

    localparam int LANES       = 64;
    localparam int DATA_WIDTH  = 16;
    localparam int SRAM_ADDR_W = 20;
    localparam int DEPTH       = 1024;
    localparam int RD_LATENCY  = 2;
    localparam int W           = LANES * DATA_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [SRAM_ADDR_W-1:0] sram_addr = '0;
    logic [W-1:0]           sram_wdata = '0;
    logic                   sram_re = 1'b0;
    logic                   sram_we = 1'b0;
    logic [W-1:0]           sram_rdata;
    logic                   sram_ready;
    logic                   dma_we = 1'b0;
    logic [SRAM_ADDR_W-1:0] dma_addr = '0;
    logic [W-1:0]           dma_wdata = '0;
    logic                   dma_ready;
    logic                   err_range;
    logic                   err_proto;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] model [int];
    logic [W-1:0] lastRead = '0;

    vpu_sram_responder #(
        .LANES(LANES), .DATA_WIDTH(DATA_WIDTH), .SRAM_ADDR_W(SRAM_ADDR_W),
        .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk(clk), .rst(rst),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_re(sram_re), .sram_we(sram_we),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready),
        .err_range(err_range), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] laneIndexWord();
        logic [W-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(i);
        return w;
    endfunction

    function automatic logic [W-1:0] fillWord(input logic [DATA_WIDTH-1:0] p);
        logic [W-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*DATA_WIDTH +: DATA_WIDTH] = p;
        return w;
    endfunction

    function automatic logic [W-1:0] randWord();
        logic [W-1:0] w;
        for (int i = 0; i < W/32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [W-1:0] expectRead(input int addr);
        if (addr >= DEPTH || !model.exists(addr)) return '0;
        return model[addr];
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputWide(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        int lane;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            lane = 0;
            for (int i = LANES - 1; i >= 0; i--)
                if (obs[i*DATA_WIDTH +: DATA_WIDTH] !== exp[i*DATA_WIDTH +: DATA_WIDTH]) lane = i;
            $error("[TB] FAIL %s: lane %0d observed %h expected %h", tag, lane,
                   obs[lane*DATA_WIDTH +: DATA_WIDTH], exp[lane*DATA_WIDTH +: DATA_WIDTH]);
        end
    endtask

    // One VPU write, optionally with sram_re raised at the same time.
    task automatic vpuWrite(input int addr, input logic [W-1:0] data, input logic alsoRead);
        sram_addr  = SRAM_ADDR_W'(addr);
        sram_wdata = data;
        sram_we    = 1'b1;
        sram_re    = alsoRead;
        #1;
        checkOutput("wr dma_ready low", 64'(dma_ready), 64'd0);
        nextCycle();
        sram_we = 1'b0;
        sram_re = 1'b0;
        if (addr < DEPTH) model[addr] = data;
        #1;
        checkOutput("wr ready", 64'(sram_ready), 64'd1);
        checkOutputWide("wr rdata hold", sram_rdata, lastRead);
        nextCycle();
        #1;
        checkOutput("wr ready drop", 64'(sram_ready), 64'd0);
    endtask

    // One VPU read, optionally with a DMA write issued in the same cycle.
    task automatic vpuRead(input int addr, input logic dmaEn, input int dAddr, input logic [W-1:0] dData);
        logic [W-1:0] exp;
        exp       = expectRead(addr);
        sram_addr = SRAM_ADDR_W'(addr);
        sram_re   = 1'b1;
        dma_we    = dmaEn;
        dma_addr  = SRAM_ADDR_W'(dAddr);
        dma_wdata = dData;
        #1;
        if (dmaEn) checkOutput("rd dma_ready", 64'(dma_ready), 64'd1);
        nextCycle();
        sram_re = 1'b0;
        dma_we  = 1'b0;
        if (dmaEn && dAddr < DEPTH) model[dAddr] = dData;
        for (int k = 1; k < RD_LATENCY; k++) begin
            #1;
            checkOutput("rd early ready", 64'(sram_ready), 64'd0);
            nextCycle();
        end
        #1;
        checkOutput("rd ready", 64'(sram_ready), 64'd1);
        checkOutputWide("rd data", sram_rdata, exp);
        lastRead = exp;
        nextCycle();
        #1;
        checkOutput("rd ready drop", 64'(sram_ready), 64'd0);
        checkOutputWide("rd data hold", sram_rdata, exp);
    endtask

    task automatic dmaWrite(input int addr, input logic [W-1:0] data);
        dma_we    = 1'b1;
        dma_addr  = SRAM_ADDR_W'(addr);
        dma_wdata = data;
        #1;
        checkOutput("dma accept", 64'(dma_ready), 64'd1);
        nextCycle();
        dma_we = 1'b0;
        if (addr < DEPTH) model[addr] = data;
    endtask

    task automatic applyStimulus();
        int op;
        int a;
        int d;
        for (int i = 16; i < 24; i++) dmaWrite(i, randWord());
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 4);
            a  = 16 + $urandom_range(0, 7);
            d  = 16 + $urandom_range(0, 7);
            case (op)
                0: vpuWrite(a, randWord(), 1'b0);
                1: vpuRead(a, 1'b0, 0, '0);
                2: vpuRead(a, 1'b1, d, randWord());
                3: vpuRead(DEPTH + int'($urandom_range(0, 1000)), 1'b0, 0, '0);
                default: dmaWrite(a, randWord());
            endcase
        end
    endtask

    initial begin
        // Reset values: a pending sram_we must not block DMA while reset is held.
        sram_we = 1'b1;
        repeat (2) nextCycle();
        #1;
        checkOutput("reset ready", 64'(sram_ready), 64'd0);
        checkOutputWide("reset rdata", sram_rdata, '0);
        checkOutput("reset err_range", 64'(err_range), 64'd0);
        checkOutput("reset err_proto", 64'(err_proto), 64'd0);
        checkOutput("reset dma_ready", 64'(dma_ready), 64'd1);
        sram_we = 1'b0;
        nextCycle();
        rst = 1'b0;
        nextCycle();

        // Write then read.
        vpuWrite(5, laneIndexWord(), 1'b0);
        vpuRead(5, 1'b0, 0, '0);

        // DMA contention: the VPU write wins, and DMA commits one cycle later.
        sram_addr  = SRAM_ADDR_W'(7);
        sram_wdata = fillWord(16'h5555);
        sram_we    = 1'b1;
        dma_we     = 1'b1;
        dma_addr   = SRAM_ADDR_W'(7);
        dma_wdata  = fillWord(16'hAAAA);
        #1;
        checkOutput("contend dma_ready low", 64'(dma_ready), 64'd0);
        nextCycle();
        sram_we  = 1'b0;
        model[7] = fillWord(16'h5555);
        #1;
        checkOutput("contend dma_ready high", 64'(dma_ready), 64'd1);
        checkOutput("contend wr ready", 64'(sram_ready), 64'd1);
        nextCycle();
        dma_we   = 1'b0;
        model[7] = fillWord(16'hAAAA);
        #1;
        checkOutput("contend ready drop", 64'(sram_ready), 64'd0);
        vpuRead(7, 1'b0, 0, '0);

        // Same-word hazard: the read returns the old value, the next read the new one.
        vpuWrite(9, fillWord(16'h0909), 1'b0);
        vpuRead(9, 1'b1, 9, fillWord(16'h9999));
        vpuRead(9, 1'b0, 0, '0);
        checkOutput("no err_range yet", 64'(err_range), 64'd0);
        checkOutput("no err_proto yet", 64'(err_proto), 64'd0);

        // Out of range: a read returns zero, and a write must not alias onto word 3.
        vpuWrite(3, fillWord(16'h0303), 1'b0);
        vpuRead(DEPTH, 1'b0, 0, '0);
        checkOutput("oor err_range", 64'(err_range), 64'd1);
        vpuWrite(DEPTH + 3, fillWord(16'hBEEF), 1'b0);
        vpuRead(3, 1'b0, 0, '0);
        checkOutput("oor err_proto clear", 64'(err_proto), 64'd0);

        // Simultaneous re+we: performed as a write.
        vpuWrite(2, fillWord(16'h1234), 1'b1);
        checkOutput("re+we err_proto", 64'(err_proto), 64'd1);
        vpuRead(2, 1'b0, 0, '0);
        checkOutput("err_range sticky", 64'(err_range), 64'd1);

        // Reset in cycle N+1 of a read cancels the response.
        sram_addr = SRAM_ADDR_W'(5);
        sram_re   = 1'b1;
        nextCycle();
        sram_re = 1'b0;
        rst     = 1'b1;
        #1;
        checkOutput("midrd ready", 64'(sram_ready), 64'd0);
        checkOutputWide("midrd rdata", sram_rdata, '0);
        checkOutput("midrd err_range", 64'(err_range), 64'd0);
        checkOutput("midrd err_proto", 64'(err_proto), 64'd0);
        repeat (2) nextCycle();
        rst      = 1'b0;
        lastRead = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("post-reset no ready", 64'(sram_ready), 64'd0);
            nextCycle();
        end
        vpuRead(5, 1'b0, 0, '0);

        // A second sram_re during RD_WAIT is ignored.
        sram_addr = SRAM_ADDR_W'(5);
        sram_re   = 1'b1;
        nextCycle();
        sram_addr = SRAM_ADDR_W'(20);
        #1;
        checkOutput("overlap early ready", 64'(sram_ready), 64'd0);
        nextCycle();
        sram_re = 1'b0;
        #1;
        checkOutput("overlap ready", 64'(sram_ready), 64'd1);
        checkOutputWide("overlap rdata", sram_rdata, expectRead(5));
        lastRead = expectRead(5);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            #1;
            checkOutput("overlap no extra ready", 64'(sram_ready), 64'd0);
        end
        checkOutput("overlap err_proto", 64'(err_proto), 64'd1);

        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
